fetch_unit: RTL

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, issues one request at a time to the instruction memory/cache, and presents the returned instruction plus PC+4 to IF/ID. Applies branch/jump redirects from ID and drives the IF/ID flush. Holds its output while the downstream stall is asserted.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds the PC, issues one request at a
//               time to instruction memory, presents instruction + PC+4 to
//               IF/ID, applies branch/jump redirects and drives the IF/ID flush.
//               Optional macro FETCH_PERF_CNT_EN builds the fetch/squash counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic        flush_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] squash_cnt_o
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_squash;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;

    assign w_redirect = branch_i | jump_i;
    assign w_target   = jump_i ? jump_target_i : branch_target_i;
    assign w_pc_next  = r_pc + c_PC_STEP;

    assign imem_req_o   = (r_state == ST_REQ);
    assign imem_addr_o  = r_pc;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_out;
    assign inst_valid_o = r_valid;
    assign flush_o      = rst_i & w_redirect;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_squash <= 1'b0;
            r_inst   <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_redirect) r_pc <= w_target;
                    if (start_i)    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_redirect) begin
                        // A response still in flight must be thrown away once it arrives.
                        r_pc     <= w_target;
                        r_squash <= ~imem_ack_i;
                    end else if (imem_ack_i) begin
                        if (r_squash) begin
                            r_squash <= 1'b0;
                        end else begin
                            r_inst   <= imem_data_i;
                            r_pc_out <= w_pc_next;
                            r_valid  <= 1'b1;
                            r_state  <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_redirect || !stall_i) begin
                        r_pc     <= w_redirect ? w_target : w_pc_next;
                        r_inst   <= '0;
                        r_pc_out <= '0;
                        r_valid  <= 1'b0;
                        r_state  <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_squash_cnt;
    logic        w_fetch_inc;
    logic        w_squash_inc;

    assign w_fetch_inc  = (r_state == ST_HOLD) && !stall_i && !w_redirect;
    assign w_squash_inc = ((r_state == ST_REQ) && imem_ack_i && (r_squash || w_redirect)) ||
                          ((r_state == ST_HOLD) && w_redirect);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_fetch_inc)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (w_squash_inc) r_squash_cnt <= r_squash_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign squash_cnt_o = r_squash_cnt;
`else
    assign fetch_cnt_o  = '0;
    assign squash_cnt_o = '0;
`endif

endmodule

`default_nettype wire
